// File: rtl/spi_esp8266_pkg.sv
// Shared constants and frame-state encoding for the ESP8266 SPI byte link
// (used by both the transmit control and the frame receiver).
package spi_esp8266_pkg;

  localparam int         NUM_BYTES = 32;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Byte positions within a frame
  localparam int OFFSET_CMD     = 0;
  localparam int OFFSET_ADDR    = 1;
  localparam int OFFSET_PAYLOAD = 2;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DISCARD
  } frame_state_t;

endpackage

// File: rtl/edge_detect_rise_fall.sv
// Single-bit edge detector: registers the previous value and flags
// rising and falling transitions combinationally in the current cycle.
module edge_detect_rise_fall (
  input  logic clock,
  input  logic reset_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sig_prev <= 1'b0;
    else          sig_prev <= sig;
  end

  assign rise = sig & ~sig_prev;
  assign fall = ~sig & sig_prev;

endmodule

// File: rtl/spi_frame_receiver_esp8266.sv
// Parses command/address/payload frames from the SPI receive side and commits
// the assembled payload to `data` when a write frame ends cleanly.
module spi_frame_receiver_esp8266 #(
  parameter int         NUM_BYTES = spi_esp8266_pkg::NUM_BYTES,
  parameter logic [7:0] CMD_WRITE = spi_esp8266_pkg::CMD_WRITE
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   do_valid,
  input  logic [7:0]             do_byte,
  input  logic                   ssel_n,
  output logic [8*NUM_BYTES-1:0] data,
  output logic                   dataValid,
  output logic                   frameError,
  output logic [7:0]             bytesReceived
);

  import spi_esp8266_pkg::*;

  localparam int         DATA_W      = 8 * NUM_BYTES;
  localparam logic [7:0] NUM_BYTES_B = 8'(NUM_BYTES);

  logic byte_ev, do_valid_fall_unused;
  logic frame_start, frame_end;

  edge_detect_rise_fall u_edge_valid (
    .clock   (clock),
    .reset_n (reset_n),
    .sig     (do_valid),
    .rise    (byte_ev),
    .fall    (do_valid_fall_unused)
  );

  edge_detect_rise_fall u_edge_ssel (
    .clock   (clock),
    .reset_n (reset_n),
    .sig     (ssel_n),
    .rise    (frame_end),
    .fall    (frame_start)
  );

  frame_state_t state, state_next, state_after_byte;

  logic [DATA_W-1:0] shadow, shadow_nxt;
  logic [7:0]        ptr, count, count_nxt;
  logic              shadow_load, cnt_clr, ptr_ld, wr_byte, commit, err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // The byte of this cycle is applied first; frame end then acts on the result.
  always_comb begin
    state_after_byte = state;
    state_next       = state;
    shadow_load      = 1'b0;
    cnt_clr          = 1'b0;
    ptr_ld           = 1'b0;
    wr_byte          = 1'b0;
    commit           = 1'b0;
    err              = 1'b0;

    case (state)
      IDLE: begin
        if (frame_start) begin
          shadow_load      = 1'b1;
          cnt_clr          = 1'b1;
          state_after_byte = CMD;
        end
      end
      CMD: begin
        if (byte_ev)
          state_after_byte = (do_byte == CMD_WRITE) ? ADDR : DISCARD;
      end
      ADDR: begin
        if (byte_ev) begin
          if (do_byte < NUM_BYTES_B) begin
            ptr_ld           = 1'b1;
            state_after_byte = DATA;
          end else begin
            state_after_byte = DISCARD;
          end
        end
      end
      DATA: begin
        if (byte_ev) begin
          if (ptr < NUM_BYTES_B) wr_byte = 1'b1;
          else                   state_after_byte = DISCARD;
        end
      end
      default: ;
    endcase

    if (state != IDLE && frame_end) begin
      state_next = IDLE;
      if (state_after_byte == DATA) commit = (count_nxt != 8'd0);
      else                          err    = 1'b1;
    end else begin
      state_next = state_after_byte;
    end
  end

  assign count_nxt = count + {7'd0, wr_byte};

  always_comb begin
    shadow_nxt = shadow;
    if (shadow_load) shadow_nxt = data;
    if (wr_byte) begin
      for (int k = 0; k < NUM_BYTES; k++)
        if (ptr == 8'(k)) shadow_nxt[8*k +: 8] = do_byte;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow        <= '0;
      ptr           <= 8'd0;
      count         <= 8'd0;
      data          <= '0;
      dataValid     <= 1'b0;
      frameError    <= 1'b0;
      bytesReceived <= 8'd0;
    end else begin
      shadow     <= shadow_nxt;
      dataValid  <= commit;
      frameError <= err;
      if (cnt_clr) count <= 8'd0;
      else         count <= count_nxt;
      if (ptr_ld)       ptr <= do_byte;
      else if (wr_byte) ptr <= ptr + 8'd1;
      if (commit) begin
        data          <= shadow_nxt;
        bytesReceived <= count_nxt;
      end
    end
  end

endmodule
